// File: rtl/core_launch_controller_if.sv
// Host-side bundle for core_launch_controller: program load stream,
// launch handshake, watchdog limit and run status.
interface core_launch_controller_if #(
    parameter int addr_width = 32,
    parameter int data_width = 32
);
    logic                  host_load_valid;
    logic [addr_width-1:0] host_load_addr;
    logic [data_width-1:0] host_load_data;
    logic                  host_load_ready;
    logic                  host_launch_req;
    logic [data_width-1:0] host_launch_pc;
    logic                  host_launch_ack;
    logic [31:0]           watchdog_limit;
    logic                  host_done;
    logic                  host_timeout;
    logic [31:0]           host_cycles;
    logic                  busy;

    modport master (
        output host_load_valid,
        output host_load_addr,
        output host_load_data,
        input  host_load_ready,
        output host_launch_req,
        output host_launch_pc,
        input  host_launch_ack,
        output watchdog_limit,
        input  host_done,
        input  host_timeout,
        input  host_cycles,
        input  busy
    );

    modport slave (
        input  host_load_valid,
        input  host_load_addr,
        input  host_load_data,
        output host_load_ready,
        input  host_launch_req,
        input  host_launch_pc,
        output host_launch_ack,
        input  watchdog_limit,
        output host_done,
        output host_timeout,
        output host_cycles,
        output busy
    );
endinterface

// File: rtl/core_launch_controller.sv
// Single-core launch controller: loads global memory, starts the core
// at a PC, waits for halt under a watchdog, reports the cycle count.
module core_launch_controller #(
    parameter int addr_width = 32,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    core_launch_controller_if.slave host,
    output logic                  contr_mem_wr_en,
    output logic [addr_width-1:0] contr_mem_wr_addr,
    output logic [data_width-1:0] contr_mem_wr_data,
    output logic                  contr_core1_clr,
    output logic                  contr_core1_set_pc_req,
    output logic [data_width-1:0] contr_core1_set_pc_addr,
    output logic                  contr_core1_ena,
    input  logic                  contr_core1_halt
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SET_PC,
        RUN,
        ABORT
    } state_t;

    state_t state_q, state_d;

    logic [data_width-1:0] pc_q, pc_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           cnt_inc;
    logic [31:0]           cycles_q, cycles_d;
    logic                  ack_d, done_d, to_d;
    logic                  accept;
    logic                  wd_hit;

    logic                  ready_q;
    logic                  ack_q, done_q, to_q, busy_q;
    logic                  wr_en_q;
    logic [addr_width-1:0] wr_addr_q;
    logic [data_width-1:0] wr_data_q;
    logic                  clr_q, set_req_q, ena_q;

    // A load takes priority over a launch in the same IDLE cycle.
    assign accept  = (state_q == IDLE) & host.host_load_valid & ready_q;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
    assign wd_hit  = (host.watchdog_limit != 32'd0) &&
                     (cnt_inc >= host.watchdog_limit);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;
        to_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!accept && host.host_launch_req) begin
                    pc_d    = host.host_launch_pc;
                    ack_d   = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = 32'd0;
                state_d = SET_PC;
            end
            SET_PC: state_d = RUN;
            RUN: begin
                cnt_d = cnt_inc;
                // Halt wins over a coincident watchdog expiry.
                if (contr_core1_halt) begin
                    done_d   = 1'b1;
                    cycles_d = cnt_inc;
                    state_d  = IDLE;
                end else if (wd_hit) begin
                    to_d     = 1'b1;
                    cycles_d = host.watchdog_limit;
                    state_d  = ABORT;
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            cycles_q  <= '0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            clr_q     <= 1'b0;
            set_req_q <= 1'b0;
            ena_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            cycles_q  <= cycles_d;
            ready_q   <= (state_d == IDLE);
            ack_q     <= ack_d;
            done_q    <= done_d;
            to_q      <= to_d;
            busy_q    <= (state_d != IDLE);
            wr_en_q   <= accept;
            if (accept) begin
                wr_addr_q <= host.host_load_addr;
                wr_data_q <= host.host_load_data;
            end
            clr_q     <= (state_d == CLEAR) || (state_d == ABORT);
            set_req_q <= (state_d == SET_PC);
            ena_q     <= (state_d == RUN);
        end
    end

    assign host.host_load_ready     = ready_q;
    assign host.host_launch_ack     = ack_q;
    assign host.host_done           = done_q;
    assign host.host_timeout        = to_q;
    assign host.host_cycles         = cycles_q;
    assign host.busy                = busy_q;
    assign contr_mem_wr_en          = wr_en_q;
    assign contr_mem_wr_addr        = wr_addr_q;
    assign contr_mem_wr_data        = wr_data_q;
    assign contr_core1_clr          = clr_q;
    assign contr_core1_set_pc_req   = set_req_q;
    assign contr_core1_set_pc_addr  = pc_q;
    assign contr_core1_ena          = ena_q;

endmodule

// File: tb/tb_core_launch_controller.sv
// Bench for core_launch_controller: write scoreboard, launch table,
// and hand-written reset sequences.
module tb_core_launch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        clr, spr, ena;
    logic [31:0] spa;
    logic        halt = 1'b0;

    always #5 clk = ~clk;

    core_launch_controller_if #(
        .addr_width(32),
        .data_width(32)
    ) hif ();

    core_launch_controller #(
        .addr_width(32),
        .data_width(32)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .host                   (hif),
        .contr_mem_wr_en        (wr_en),
        .contr_mem_wr_addr      (wr_addr),
        .contr_mem_wr_data      (wr_data),
        .contr_core1_clr        (clr),
        .contr_core1_set_pc_req (spr),
        .contr_core1_set_pc_addr(spa),
        .contr_core1_ena        (ena),
        .contr_core1_halt       (halt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Write scoreboard: expected memory writes queued at acceptance.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t sb[$];
    wr_t e;

    always @(negedge clk) begin
        if (rst && wr_en) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 32'(wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Core model: halts after halt_after enabled cycles, cleared by clr.
    int run_cnt = 0;
    int halt_after = 0;

    always @(negedge clk) begin
        if (clr) begin
            run_cnt = 0;
            halt    = 1'b0;
        end else if (ena) begin
            run_cnt++;
            if (halt_after != 0 && run_cnt == halt_after) halt = 1'b1;
        end
    end

    typedef struct {
        logic [31:0] pc;
        int          halt_after;
        logic [31:0] limit;
        bit          coll;
        bit          bad_load;
        int          exp_ena;
        bit          exp_done;
        bit          exp_to;
        logic [31:0] exp_cycles;
    } run_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ld_t;

    run_t runs[6];
    ld_t  lds[3];
    run_t t;
    int n_ack, ack_i, n_clr, clr_i, n_sp, sp_i, n_ena, ena_i;
    int n_done, n_to, n_wr, n_pulse;
    logic [31:0] sp_addr;

    initial begin
        lds[0] = '{32'h0, 32'h0000_0013};
        lds[1] = '{32'h4, 32'h0010_0073};
        lds[2] = '{32'h8, 32'hDEAD_BEEF};

        runs[0] = '{32'h40,   10, 32'd0,  0, 0, 10, 1, 0, 32'd10};
        runs[1] = '{32'h100,   0, 32'd5,  0, 0,  5, 0, 1, 32'd5};
        runs[2] = '{32'h80,    7, 32'd7,  0, 0,  7, 1, 0, 32'd7};
        runs[3] = '{32'h1234,  3, 32'd20, 1, 0,  3, 1, 0, 32'd3};
        runs[4] = '{32'h44,    4, 32'd0,  0, 1,  4, 1, 0, 32'd4};
        runs[5] = '{32'h48,    0, 32'd1,  0, 0,  1, 0, 1, 32'd1};

        // Reset with random inputs: every output held at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hif.host_load_valid = 1'($urandom);
            hif.host_load_addr  = $urandom;
            hif.host_load_data  = $urandom;
            hif.host_launch_req = 1'($urandom);
            hif.host_launch_pc  = $urandom;
            hif.watchdog_limit  = $urandom;
            #1;
            chk("reset_outs", 32'(|{wr_en, wr_addr, wr_data, clr, spr,
                spa, ena, hif.host_load_ready, hif.host_launch_ack,
                hif.host_done, hif.host_timeout, hif.host_cycles,
                hif.busy}), 32'd0);
        end
        @(negedge clk);
        hif.host_load_valid = 1'b0;
        hif.host_load_addr  = '0;
        hif.host_load_data  = '0;
        hif.host_launch_req = 1'b0;
        hif.host_launch_pc  = '0;
        hif.watchdog_limit  = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(hif.host_load_ready), 32'd1);
        chk("rel_busy", 32'(hif.busy), 32'd0);

        // Back-to-back loads.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hif.host_load_valid = 1'b1;
            hif.host_load_addr  = lds[i].addr;
            hif.host_load_data  = lds[i].data;
            chk("load_ready", 32'(hif.host_load_ready), 32'd1);
            sb.push_back('{lds[i].addr, lds[i].data, cyc + 1});
        end
        @(negedge clk);
        hif.host_load_valid = 1'b0;
        @(negedge clk);
        chk("load_drain", sb.size(), 32'd0);

        // Launch table.
        for (int r = 0; r < 6; r++) begin
            t = runs[r];
            @(negedge clk);
            halt_after          = t.halt_after;
            hif.host_launch_req = 1'b1;
            hif.host_launch_pc  = t.pc;
            hif.watchdog_limit  = t.limit;
            if (t.coll) begin
                hif.host_load_valid = 1'b1;
                hif.host_load_addr  = 32'hC;
                hif.host_load_data  = 32'hC0FF_EE00;
                sb.push_back('{32'hC, 32'hC0FF_EE00, cyc + 1});
            end
            n_ack = 0; ack_i = -1; n_clr = 0; clr_i = -1;
            n_sp = 0; sp_i = -1; n_ena = 0; ena_i = -1;
            n_done = 0; n_to = 0; n_wr = 0; sp_addr = '0;
            for (int i = 0; i < t.exp_ena + 10; i++) begin
                @(negedge clk);
                hif.host_load_valid = t.bad_load && ena;
                hif.host_load_addr  = 32'h100 + 32'(i);
                hif.host_load_data  = 32'(i);
                if (hif.host_launch_ack) begin
                    n_ack++;
                    if (ack_i < 0) ack_i = i;
                    hif.host_launch_req = 1'b0;
                end
                if (clr) begin
                    n_clr++;
                    if (clr_i < 0) clr_i = i;
                end
                if (spr) begin
                    n_sp++;
                    sp_i = i;
                    sp_addr = spa;
                end
                if (ena) begin
                    n_ena++;
                    if (ena_i < 0) ena_i = i;
                end
                n_done += int'(hif.host_done);
                n_to   += int'(hif.host_timeout);
                if (t.bad_load && wr_en) n_wr++;
            end
            hif.host_launch_req = 1'b0;
            hif.host_load_valid = 1'b0;
            chk("ack_cnt", n_ack, 32'd1);
            chk("ack_idx", ack_i, t.coll ? 32'd1 : 32'd0);
            chk("clr_cnt", n_clr, t.exp_to ? 32'd2 : 32'd1);
            chk("clr_idx", clr_i, ack_i);
            chk("setpc_cnt", n_sp, 32'd1);
            chk("setpc_idx", sp_i, clr_i + 1);
            chk("setpc_addr", sp_addr, t.pc);
            chk("ena_cnt", n_ena, t.exp_ena);
            chk("ena_idx", ena_i, sp_i + 1);
            chk("done_cnt", n_done, 32'(t.exp_done));
            chk("timeout_cnt", n_to, 32'(t.exp_to));
            chk("host_cycles", hif.host_cycles, t.exp_cycles);
            chk("end_busy", 32'(hif.busy), 32'd0);
            chk("end_ready", 32'(hif.host_load_ready), 32'd1);
            if (t.bad_load) chk("run_load_wr", n_wr, 32'd0);
        end
        chk("sb_drain", sb.size(), 32'd0);

        // Async reset mid-RUN.
        @(negedge clk);
        halt_after          = 0;
        hif.host_launch_req = 1'b1;
        hif.host_launch_pc  = 32'h300;
        hif.watchdog_limit  = 32'd0;
        for (int i = 0; i < 20 && !ena; i++) begin
            @(negedge clk);
            if (hif.host_launch_ack) hif.host_launch_req = 1'b0;
        end
        hif.host_launch_req = 1'b0;
        chk("rr_ena_seen", 32'(ena), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rr_ena", 32'(ena), 32'd0);
        chk("rr_clr", 32'(clr), 32'd0);
        chk("rr_wr", 32'(wr_en), 32'd0);
        chk("rr_busy", 32'(hif.busy), 32'd0);
        n_pulse = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            n_pulse += int'(hif.host_done | hif.host_timeout);
        end
        chk("rr_pulses", n_pulse, 32'd0);
        chk("rr_ready", 32'(hif.host_load_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_launch_controller.md
Name: core_launch_controller

Overview:
- Controller-side initiator for a single core plus its global memory: drives the contr_mem_wr_* and contr_core1_* ports that the core/memory pair exposes.
- Host-facing side:
  - Streams program/data words into global memory.
  - Launches the core at a given PC.
  - Waits for halt, with a watchdog.
  - Reports completion and cycle count.
- Sits between the host/testbench and the core+memory pair; it is the minimal GPU-controller stand-in for single-core runs.

Parameters:
- addr_width, 32, memory address width.
- data_width, 32, memory data width and PC width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock, reset is asynchronous and active-low.
- host_load_valid  input  1  load word request.
- host_load_addr  input  addr_width  load address.
- host_load_data  input  data_width  load data.
- host_load_ready  output  1  load accepted when valid&ready.
- host_launch_req  input  1  launch request; held until ack.
- host_launch_pc  input  data_width  start PC.
- host_launch_ack  output  1  one-cycle pulse, launch accepted.
- watchdog_limit  input  32  max RUN cycles; 0 disables.
- host_done  output  1  one-cycle pulse, core halted.
- host_timeout  output  1  one-cycle pulse, watchdog expired.
- host_cycles  output  32  RUN cycle count of last run.
- busy  output  1  high in any state except IDLE.
- contr_mem_wr_en  output  1  memory write strobe.
- contr_mem_wr_addr  output  addr_width  memory write address.
- contr_mem_wr_data  output  data_width  memory write data.
- contr_core1_clr  output  1  core clear.
- contr_core1_set_pc_req  output  1  core set-PC strobe.
- contr_core1_set_pc_addr  output  data_width  PC value.
- contr_core1_ena  output  1  core enable.
- contr_core1_halt  input  1  core halted.

Behaviour:
- All outputs registered. On rst low: every output 0, state IDLE, latched PC 0, counter 0.
- States: IDLE, CLEAR, SET_PC, RUN, ABORT.
- IDLE:
  - host_load_ready=1.
  - valid&ready → next cycle contr_mem_wr_en=1 with registered addr/data for exactly one cycle. Back-to-back loads give one write per cycle.
  - Load and launch_req in the same cycle: load wins; launch stays pending (host holds req).
  - launch_req with no load: latch host_launch_pc, pulse host_launch_ack next cycle, go CLEAR.
- CLEAR (1 cycle): contr_core1_clr=1; counter ← 0; host_load_ready=0; → SET_PC.
- SET_PC (1 cycle): contr_core1_set_pc_req=1, contr_core1_set_pc_addr=latched PC; → RUN.
- RUN:
  - contr_core1_ena=1.
  - Counter increments once per RUN cycle and saturates at 0xFFFFFFFF.
  - contr_core1_halt is ignored in CLEAR and SET_PC, and sampled in RUN only.
- RUN exits:
  - halt=1 → next cycle: ena=0, host_done=1, host_cycles ← counter incl. current cycle, → IDLE.
  - watchdog_limit≠0 and count reaches watchdog_limit → ena=0, host_timeout=1, host_cycles ← limit, → ABORT.
  - halt and watchdog in the same cycle: halt wins (done, no timeout).
- ABORT (1 cycle): contr_core1_clr=1; → IDLE.
- host_load_valid outside IDLE: ignored; no write issued.
- Async reset mid-RUN: ena, clr and wr_en drop immediately; the launch is lost and no done/timeout pulse is produced.
- host_cycles holds its value until the next done or timeout.

Test Plan:
- Reset: rst low with random inputs → all outputs 0, busy=0, host_load_ready=1 after release.
- Loads: 3 words (0x0→0x00000013, 0x4→0x00100073, 0x8→0xDEADBEEF) back-to-back → 3 consecutive contr_mem_wr_en cycles, each one cycle after acceptance, with exact addr/data.
- Launch:
  - launch pc=0x40, core halts after 10 RUN cycles → ack pulse.
  - clr 1 cycle, then set_pc_req with addr 0x40, then ena for 10 cycles.
  - host_done pulse, host_cycles=10, busy=0.
- Watchdog: limit=5, halt never asserts → ena exactly 5 cycles, host_timeout pulse, host_cycles=5, one clr cycle in ABORT, no host_done.
- Collisions:
  - Load and launch in the same IDLE cycle → write issued, launch acked a cycle later.
  - Halt and watchdog limit coincide → host_done only.
- Illegal and abort:
  - host_load_valid during RUN → no contr_mem_wr_en.
  - rst low mid-RUN → ena drops asynchronously; no done/timeout pulse.
